// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the memory port arbiter.
// Contents:
//   - the arbiter state encoding
//   - the grant encoding used by the round-robin bit
//   - the default widths and timeout
//   - the width of the BUSY cycle counter
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;

  // Wide enough for any TIMEOUT in 1..255.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the three handshakes around the arbiter.
// Signal groups:
//   - fetch requester: if_req/if_addr in, if_ack/if_rdata back
//   - data requester:  d_req/d_we/d_addr/d_wdata in, d_ack/d_rdata back
//   - memory port:     mem_req/mem_we/mem_addr/mem_wdata out, mem_ack/mem_rdata back
// Modports:
//   - master: the arbiter's view
//   - slave:  the view of the requesters and the memory around it
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter
// Counts BUSY cycles for the arbiter's memory timeout.
// Ports:
//   clk, reset - clock, asynchronous active-low reset
//   clear      - hold the count at zero (arbiter idle)
//   enable     - count one per cycle (arbiter busy)
//   expired    - high in the cycle whose closing edge brings the count to TIMEOUT
module mem_timeout_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // Look-ahead so the arbiter can register its timeout completion on the
  // same edge that the count reaches TIMEOUT.
  assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between an instruction-fetch and a data requester.
// Ports:
//   clk   - clock
//   reset - asynchronous active-low reset
//   bus   - fetch, data and memory handshakes (master modport)
//   busy  - high while a memory transaction is outstanding
//   err   - one-cycle pulse alongside an ack that ended by timeout
// Behaviour:
//   - conflicts are settled round-robin
//   - the granted request is latched onto the memory port until mem_ack
//     or until the timeout expires
//   - every output comes straight from a flop
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus,
  output logic               busy,
  output logic               err
);

  state_t            state;
  grant_t            last_grant;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_ack_q, d_ack_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              busy_q, err_q;
  logic              tmo_expired;

  // A requester is ignored during its own ack cycle: it may still be holding
  // req while it sees the ack, and that must not start a second transaction.
  logic if_elig, d_elig, contested, grant_if, grant_d;
  assign if_elig   = bus.if_req & ~if_ack_q;
  assign d_elig    = bus.d_req & ~d_ack_q;
  assign contested = if_elig & d_elig;
  assign grant_if  = if_elig & (~d_elig | (last_grant == GRANT_D));
  assign grant_d   = d_elig & ~grant_if;

  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == IDLE),
    .enable  (state != IDLE),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_grant  <= GRANT_D;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        IDLE: begin
          // The round-robin bit only moves when both sides contended, so a
          // lone request never costs the other side its next conflict win.
          if (grant_if) begin
            state       <= IF_BUSY;
            busy_q      <= 1'b1;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
            if (contested) last_grant <= GRANT_IF;
          end else if (grant_d) begin
            state       <= D_BUSY;
            busy_q      <= 1'b1;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            if (contested) last_grant <= GRANT_D;
          end
        end
        IF_BUSY, D_BUSY: begin
          // mem_ack takes priority over a coincident timeout.
          if (bus.mem_ack || tmo_expired) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            mem_req_q <= 1'b0;
            err_q     <= ~bus.mem_ack;
            if (state == IF_BUSY) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus.mem_ack ? bus.mem_rdata : '0;
            end else begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= (bus.mem_ack && !mem_we_q) ? bus.mem_rdata : '0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy_q    <= 1'b0;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with TIMEOUT = 4.
// The bench plays both requesters and the memory.
// Inputs are changed and outputs are sampled 1 ns after each rising edge.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  logic busy, err;
  int   n_checks;
  int   n_pass;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    // Reset state
    tick();
    tick();
    chk("rst_busy",     {31'b0, busy}, 32'h0);
    chk("rst_err",      {31'b0, err}, 32'h0);
    chk("rst_mem_req",  {31'b0, bus.mem_req}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_if_ack",   {31'b0, bus.if_ack}, 32'h0);
    chk("rst_d_ack",    {31'b0, bus.d_ack}, 32'h0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_d_rdata",  bus.d_rdata, 32'h0);
    reset = 1'b1;

    // Zero-wait fetch; the requester keeps if_req up through its ack cycle
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    tick();
    chk("f1_mem_req",  {31'b0, bus.mem_req}, 32'h1);
    chk("f1_mem_addr", bus.mem_addr, 32'h100);
    chk("f1_mem_we",   {31'b0, bus.mem_we}, 32'h0);
    chk("f1_busy",     {31'b0, busy}, 32'h1);
    chk("f1_if_ack",   {31'b0, bus.if_ack}, 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h00500093;
    tick();
    chk("f2_if_ack",   {31'b0, bus.if_ack}, 32'h1);
    chk("f2_if_rdata", bus.if_rdata, 32'h00500093);
    chk("f2_mem_req",  {31'b0, bus.mem_req}, 32'h0);
    chk("f2_busy",     {31'b0, busy}, 32'h0);
    chk("f2_err",      {31'b0, err}, 32'h0);
    bus.mem_ack = 1'b0;
    tick();
    chk("f3_no_dup_req", {31'b0, bus.mem_req}, 32'h0);
    chk("f3_if_ack",     {31'b0, bus.if_ack}, 32'h0);
    chk("f3_if_rdata",   bus.if_rdata, 32'h00500093);
    bus.if_req = 1'b0;

    // mem_ack while idle has no effect
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h00001234;
    tick();
    chk("idle_ack_if_ack", {31'b0, bus.if_ack}, 32'h0);
    chk("idle_ack_d_ack",  {31'b0, bus.d_ack}, 32'h0);
    chk("idle_ack_rdata",  bus.if_rdata, 32'h00500093);
    chk("idle_ack_busy",   {31'b0, busy}, 32'h0);
    bus.mem_ack = 1'b0;

    // Fresh reset, then both requesters at once: fetch first
    reset = 1'b0;
    tick();
    chk("rst2_if_rdata", bus.if_rdata, 32'h0);
    reset = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h104;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h300;
    tick();
    chk("c1_mem_addr", bus.mem_addr, 32'h104);
    chk("c1_mem_we",   {31'b0, bus.mem_we}, 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hAAAA0001;
    tick();
    chk("c1_if_ack",   {31'b0, bus.if_ack}, 32'h1);
    chk("c1_if_rdata", bus.if_rdata, 32'hAAAA0001);
    chk("c1_d_ack",    {31'b0, bus.d_ack}, 32'h0);
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    tick();
    chk("c2_mem_req",  {31'b0, bus.mem_req}, 32'h1);
    chk("c2_mem_addr", bus.mem_addr, 32'h300);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBBBB0002;
    tick();
    chk("c2_d_ack",    {31'b0, bus.d_ack}, 32'h1);
    chk("c2_d_rdata",  bus.d_rdata, 32'hBBBB0002);
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    tick();
    chk("c2_hold_if_rdata", bus.if_rdata, 32'hAAAA0001);
    chk("c2_hold_d_rdata",  bus.d_rdata, 32'hBBBB0002);

    // Second conflict goes to data: a write with a 3-cycle ack delay
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h108;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h200;
    bus.d_wdata = 32'hDEADBEEF;
    tick();
    chk("w1_mem_we",    {31'b0, bus.mem_we}, 32'h1);
    chk("w1_mem_addr",  bus.mem_addr, 32'h200);
    chk("w1_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    bus.d_addr  = 32'h999;
    bus.d_wdata = 32'h0;
    bus.d_we    = 1'b0;
    tick();
    chk("w2_mem_req",   {31'b0, bus.mem_req}, 32'h1);
    chk("w2_mem_we",    {31'b0, bus.mem_we}, 32'h1);
    chk("w2_mem_addr",  bus.mem_addr, 32'h200);
    chk("w2_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    tick();
    chk("w3_mem_addr",  bus.mem_addr, 32'h200);
    chk("w3_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("w3_d_ack",     {31'b0, bus.d_ack}, 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h55555555;
    tick();
    chk("w4_d_ack",    {31'b0, bus.d_ack}, 32'h1);
    chk("w4_d_rdata",  bus.d_rdata, 32'h0);
    chk("w4_mem_req",  {31'b0, bus.mem_req}, 32'h0);
    chk("w4_err",      {31'b0, err}, 32'h0);
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    tick();
    chk("f4_mem_addr",  bus.mem_addr, 32'h108);
    chk("f4_mem_we",    {31'b0, bus.mem_we}, 32'h0);
    chk("f4_mem_wdata", bus.mem_wdata, 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h11112222;
    tick();
    chk("f4_if_rdata", bus.if_rdata, 32'h11112222);
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    tick();

    // Zero-wait read so the timeout's rdata clear is visible
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h380;
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE0000;
    tick();
    chk("r_d_rdata", bus.d_rdata, 32'hCAFE0000);
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    tick();

    // Read that never gets mem_ack: timeout after 4 BUSY cycles
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h400;
    tick();
    tick();
    tick();
    tick();
    chk("t4_mem_req", {31'b0, bus.mem_req}, 32'h1);
    chk("t4_d_ack",   {31'b0, bus.d_ack}, 32'h0);
    chk("t4_err",     {31'b0, err}, 32'h0);
    tick();
    chk("t5_d_ack",   {31'b0, bus.d_ack}, 32'h1);
    chk("t5_err",     {31'b0, err}, 32'h1);
    chk("t5_d_rdata", bus.d_rdata, 32'h0);
    chk("t5_mem_req", {31'b0, bus.mem_req}, 32'h0);
    chk("t5_busy",    {31'b0, busy}, 32'h0);
    bus.d_req = 1'b0;
    tick();
    chk("t6_err", {31'b0, err}, 32'h0);

    // mem_ack on the edge the counter would expire: normal completion
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h404;
    tick();
    tick();
    tick();
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0F0F0F0F;
    tick();
    chk("race_d_ack",   {31'b0, bus.d_ack}, 32'h1);
    chk("race_err",     {31'b0, err}, 32'h0);
    chk("race_d_rdata", bus.d_rdata, 32'h0F0F0F0F);
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    tick();

    // Reset during IF_BUSY, then a late mem_ack after release
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h500;
    tick();
    chk("ar_mem_req_before", {31'b0, bus.mem_req}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_mem_req_async", {31'b0, bus.mem_req}, 32'h0);
    chk("ar_busy_async",    {31'b0, busy}, 32'h0);
    bus.if_req = 1'b0;
    tick();
    reset         = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h00000077;
    tick();
    chk("ar_if_ack",   {31'b0, bus.if_ack}, 32'h0);
    chk("ar_busy",     {31'b0, busy}, 32'h0);
    chk("ar_mem_req",  {31'b0, bus.mem_req}, 32'h0);
    chk("ar_if_rdata", bus.if_rdata, 32'h0);
    bus.mem_ack = 1'b0;
    tick();
    chk("ar_if_ack2", {31'b0, bus.if_ack}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
